gray_count_monitor: RTL

GRAY_COUNT_MONITOR -- requirements
Module: gray_count_monitor

---
 rtl/gray_count_monitor.sv | 80 ++++++++
 1 files changed

// File: rtl/gray_count_monitor.sv
// gray_count_monitor: Gray-to-binary decoder with a +0/+1 step checker, sticky fault and saturating error count.
// Define GRAY_SYNC_EN to add a two-flop synchronizer on gray_in and sample_en.
module gray_count_monitor #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 sample_en,
  input  logic                 clear_err,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 step_err,
  output logic                 fault,
  output logic [ERR_CNT_W-1:0] err_count
);
  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     gray_s, dec, delta, prev_bin_q;
  logic                 en_s, illegal, bin_valid_q, step_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
`ifdef GRAY_SYNC_EN
  logic [WIDTH-1:0] gray_s1_q, gray_s2_q;
  logic             en_s1_q, en_s2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_s1_q <= '0;
      gray_s2_q <= '0;
      en_s1_q   <= 1'b0;
      en_s2_q   <= 1'b0;
    end else begin
      gray_s1_q <= gray_in;
      gray_s2_q <= gray_s1_q;
      en_s1_q   <= sample_en;
      en_s2_q   <= en_s1_q;
    end
  end
  assign gray_s = gray_s2_q;
  assign en_s   = en_s2_q;
`else
  assign gray_s = gray_in;
  assign en_s   = sample_en;
`endif
  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    assign dec[i] = ^gray_s[WIDTH-1:i];
  end
  assign delta   = dec - prev_bin_q;
  assign illegal = en_s && (state_q != INIT) && (delta[WIDTH-1:1] != '0);
  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    state_d   = illegal                          ? FAULT :
                (state_q == INIT && en_s)        ? TRACK :
                (state_q == FAULT && clear_err)  ? TRACK : state_q;
    err_cnt_d = illegal   ? (clear_err ? ERR_CNT_W'(1) : (&err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1)) :
                clear_err ? '0 : err_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      prev_bin_q  <= '0;
      bin_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_bin_q  <= en_s ? dec : prev_bin_q;
      bin_valid_q <= en_s;
      step_err_q  <= illegal;
      err_cnt_q   <= err_cnt_d;
    end
  end
  assign bin_out   = prev_bin_q;
  assign bin_valid = bin_valid_q;
  assign step_err  = step_err_q;
  assign fault     = (state_q == FAULT);
  assign err_count = err_cnt_q;
endmodule
